// File: rtl/hs_sync_pkg.sv
// hs_sync_pkg: shared types and helpers for the bundled-data synchronising
// receiver (and future transmit-side) blocks.
//   rx_state_t : receive-side handshake FSM states
//   ptr_w()    : FIFO pointer width, one extra wrap bit above the address
package hs_sync_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_t;

  // Address bits plus one wrap bit so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/bitsync.sv
// bitsync: reset-to-0 flop chain for bringing an asynchronous level into
// the clk domain.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears every stage
//   d   : asynchronous input level
//   q   : synchronised level, STAGES edges behind d
module bitsync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw input through the metastability chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/hlatch_sync_rx.sv
// hlatch_sync_rx: clocked receiving end of a four-phase bundled-data
// channel. The request is synchronised, the bundled word is captured into
// a small FIFO, the acknowledge comes straight from a flop, and the words
// leave as a valid/ready stream.
//   clk     : sole clock
//   rst     : asynchronous active-low reset (drops a_i at once, flushes FIFO)
//   r_i     : four-phase request from the async sender
//   a_i     : acknowledge to the async sender, registered
//   d_i     : bundled data, stable around the request
//   valid_o : data_o holds a word
//   ready_i : consumer takes the word on valid_o && ready_i
//   data_o  : head-of-FIFO word
//   count_o : FIFO occupancy
module hlatch_sync_rx
  import hs_sync_pkg::*;
#(
  parameter int N           = 1,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r_i,
  output logic                     a_i,
  input  logic [N-1:0]             d_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [N-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic            r_s;
  rx_state_t       state_r;
  rx_state_t       state_next_s;
  logic            push_s;
  logic            pop_s;
  logic            ack_next_s;
  logic            full_s;
  logic            a_r;
  logic            valid_r;
  logic            valid_next_s;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   count_r;
  logic [PW-1:0]   count_next_s;
  logic [N-1:0]    mem_r [DEPTH];

  bitsync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (r_i),
    .q   (r_s)
  );

  // Full uses the registered pointers only, so a same-cycle pop never
  // makes room for a push (no bypass path).
  assign full_s = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s  = valid_r && ready_i;

  // Handshake FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake FSM next-state: a request is only taken while there is room.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (r_s && !full_s) begin
          state_next_s = ACK;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACK: begin
        if (!r_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ACK;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake FSM outputs: write strobe and the next acknowledge level.
  always_comb begin
    push_s     = 1'b0;
    ack_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        push_s     = r_s && !full_s;
        ack_next_s = r_s && !full_s;
      end
      ACK: begin
        push_s     = 1'b0;
        ack_next_s = r_s;
      end
      default: begin
        push_s     = 1'b0;
        ack_next_s = 1'b0;
      end
    endcase
  end

  // Occupancy update: push and pop together leave the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + PTR_ONE;
      2'b01:   count_next_s = count_r - PTR_ONE;
      default: count_next_s = count_r;
    endcase
    valid_next_s = (count_next_s != {PW{1'b0}});
  end

  // Acknowledge flop: the only driver of a_i, so it cannot glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= 1'b0;
    end else begin
      a_r <= ack_next_s;
    end
  end

  // FIFO pointers, occupancy and valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {PW{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      valid_r <= valid_next_s;
    end
  end

  // FIFO storage, no reset; d_i is sampled unsynchronised because the
  // bundled-data timing has it settled long before r_s rises.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= d_i;
    end
  end

  assign a_i     = a_r;
  assign valid_o = valid_r;
  assign count_o = count_r;
  assign data_o  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: tb/tb_hlatch_sync_rx.sv
// tb_hlatch_sync_rx: directed bench for hlatch_sync_rx (N=8, DEPTH=4,
// SYNC_STAGES=2). A queue-based model of the channel is checked against the
// DUT every cycle; directed tests add hand-computed literal expectations.
module tb_hlatch_sync_rx;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         r_i;
  logic         a_i;
  logic [N-1:0] d_i;
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] data_o;
  logic [2:0]   count_o;

  int vectors     = 0;
  int miscompares = 0;

  hlatch_sync_rx #(
    .N           (N),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .r_i     (r_i),
    .a_i     (a_i),
    .d_i     (d_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Words held in a queue; r_s is r_i as sampled SS edges earlier.
  logic [N-1:0] mq[$];
  bit           m_ack;
  bit           rh[$];

  initial begin
    m_ack = 1'b0;
    for (int i = 0; i < SS; i++) rh.push_back(1'b0);
    forever begin
      @(posedge clk or negedge rst);
      if (rst !== 1'b1) begin
        mq.delete();
        m_ack = 1'b0;
        rh.delete();
        for (int i = 0; i < SS; i++) rh.push_back(1'b0);
      end else begin
        bit rs;
        bit pu;
        bit po;
        rs = rh[SS-1];
        rh.push_front(r_i);
        void'(rh.pop_back());
        po = (mq.size() != 0) && ready_i;
        pu = !m_ack && rs && (mq.size() < DEPTH);
        if (!m_ack) begin
          if (pu) m_ack = 1'b1;
        end else if (!rs) begin
          m_ack = 1'b0;
        end
        if (po) void'(mq.pop_front());
        if (pu) mq.push_back(d_i);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit           collect = 1'b0;
  logic [N-1:0] out_q[$];
  int           max_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("a_i", {31'd0, a_i}, {31'd0, m_ack});
      chk("count_o", {29'd0, count_o}, mq.size());
      chk("valid_o", {31'd0, valid_o}, {31'd0, (mq.size() != 0)});
      if (mq.size() != 0) chk("data_o", {24'd0, data_o}, {24'd0, mq[0]});
      if (collect) begin
        if (valid_o && ready_i) out_q.push_back(data_o);
        if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_a(input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (a_i !== lvl && n < 30);
  endtask

  task automatic hs(input logic [N-1:0] d);
    int n;
    d_i = d;
    r_i = 1'b1;
    wait_a(1'b1, n);
    chk("hs_up_edges", n, 32'd3);
    r_i = 1'b0;
    wait_a(1'b0, n);
    chk("hs_down_edges", n, 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    rst = 1'b0; r_i = 1'b0; ready_i = 1'b0; d_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_i", {31'd0, a_i}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single word with ready held high.
    ready_i = 1'b1; d_i = 8'hA5; r_i = 1'b1;
    wait_a(1'b1, n);
    chk("t1_ack_edges", n, 32'd3);
    chk("t1_valid", {31'd0, valid_o}, 32'd1);
    chk("t1_data", {24'd0, data_o}, 32'hA5);
    @(posedge clk); #1;
    chk("t1_popped", {31'd0, valid_o}, 32'd0);
    r_i = 1'b0;
    wait_a(1'b0, n);
    chk("t1_ackdown_edges", n, 32'd3);

    // Fill to DEPTH, fifth request is held off.
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) hs(8'(i));
    chk("fill_count4", {29'd0, count_o}, 32'd4);
    d_i = 8'd5; r_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("fill_no_ack", {31'd0, a_i}, 32'd0);
    chk("fill_count_hold", {29'd0, count_o}, 32'd4);
    chk("fill_head", {24'd0, data_o}, 32'd1);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("fill_after_pop", {29'd0, count_o}, 32'd3);
    wait_a(1'b1, n);
    chk("fill_5th_edges", n, 32'd1);
    chk("fill_count_again", {29'd0, count_o}, 32'd4);
    r_i = 1'b0;
    wait_a(1'b0, n);
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("fill_valid", {31'd0, valid_o}, 32'd1);
      chk("fill_order", {24'd0, data_o}, 32'(k + 2));
      @(posedge clk); #1;
    end
    chk("fill_drained", {29'd0, count_o}, 32'd0);

    // Pointer wrap, ten words with ready high.
    collect = 1'b1;
    for (int i = 0; i < 10; i++) hs(8'(i));
    repeat (2) @(posedge clk);
    #1;
    collect = 1'b0;
    chk("wrap_len", out_q.size(), 32'd10);
    for (int i = 0; i < 10 && i < out_q.size(); i++)
      chk("wrap_order", {24'd0, out_q[i]}, 32'(i));
    chk("wrap_max_le1", max_cnt, 32'd1);

    // Push and pop on the same edge at count 2.
    ready_i = 1'b0;
    hs(8'h10);
    hs(8'h11);
    chk("sim_count2", {29'd0, count_o}, 32'd2);
    d_i = 8'h12; r_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("sim_ack", {31'd0, a_i}, 32'd1);
    chk("sim_count_same", {29'd0, count_o}, 32'd2);
    chk("sim_head", {24'd0, data_o}, 32'h11);
    r_i = 1'b0;
    wait_a(1'b0, n);
    ready_i = 1'b1;
    chk("sim_out0", {24'd0, data_o}, 32'h11);
    @(posedge clk); #1;
    chk("sim_out1", {24'd0, data_o}, 32'h12);
    @(posedge clk); #1;
    chk("sim_empty", {31'd0, valid_o}, 32'd0);
    ready_i = 1'b0;

    // Asynchronous reset while in ACK with three words held.
    hs(8'h20);
    hs(8'h21);
    d_i = 8'h22; r_i = 1'b1;
    wait_a(1'b1, n);
    chk("rm_count3", {29'd0, count_o}, 32'd3);
    rst = 1'b0;
    r_i = 1'b0;
    #1;
    chk("rm_a_i", {31'd0, a_i}, 32'd0);
    chk("rm_valid", {31'd0, valid_o}, 32'd0);
    chk("rm_count", {29'd0, count_o}, 32'd0);

    // Request already high when reset is released.
    d_i = 8'h77; r_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_a(1'b1, n);
    chk("rel_ack_edges", n, 32'd3);
    chk("rel_data", {24'd0, data_o}, 32'h77);
    chk("rel_count", {29'd0, count_o}, 32'd1);
    r_i = 1'b0;
    wait_a(1'b0, n);
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("rel_drained", {29'd0, count_o}, 32'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hlatch_sync_rx.md
# hlatch_sync_rx

Clocked receiving end of the four-phase bundled-data handshake channel driven by the async pipeline stages (`r`/`a`/`d`). Synchronises the incoming request, captures the bundled data into a small FIFO, returns the acknowledge from a register, and presents the words to synchronous logic as a valid/ready stream. It is the exit point of an async pipeline into a clocked domain.

## Interface
- `N`, 1: data width in bits.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: flops in the `r_i` synchroniser; ≥2.
- `clk` input 1: sole clock.
- `rst` input 1: reset, asynchronous, active-low (`rst`=0 resets).
- `r_i` input 1: four-phase request from the async sender.
- `a_i` output 1: acknowledge to the async sender; driven directly from a flop.
- `d_i` input N: bundled data; stable from before `r_i`↑ until after `a_i`↑.
- `valid_o` output 1: `data_o` holds a word.
- `ready_i` input 1: consumer accepts the word when `valid_o && ready_i` at a `clk` edge.
- `data_o` output N: head-of-FIFO word.
- `count_o` output clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Reset values: `a_i`=0, `valid_o`=0, `count_o`=0, FSM=IDLE, FIFO pointers=0, synchroniser flops=0. `data_o` is don't-care while `valid_o`=0.
- `r_s` is `r_i` after `SYNC_STAGES` flops.
- FSM states:
  - IDLE (`a_i`=0):
    - `r_s`=1 and FIFO not full: write `d_i` at `wr_ptr`, increment `wr_ptr`, go to ACK.
    - `r_s`=1 and FIFO full: stay in IDLE with no write. This back-pressures the sender.
    - `r_s`=0: stay in IDLE.
  - ACK (`a_i`=1): when `r_s`=0, go to IDLE. Otherwise hold.
- `d_i` is sampled directly, without synchronisation. The bundled-data rule guarantees it is stable by the time `r_s` is high.
- Pop: `valid_o && ready_i` increments `rd_ptr`.
- `valid_o` = (count≠0). `data_o` = mem[`rd_ptr`].
- Full is evaluated on the registered count before any same-cycle pop. A pop does not create room in the same cycle, so there is no bypass path.
- Simultaneous push and pop leave `count_o` unchanged, and both pointers advance.
- Pointers are clog2(DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and low bits are equal.
  - empty = pointers equal.
- If `r_i` is high when `rst` is released, it is treated as a new request and accepted.
- Reset mid-handshake:
  - `a_i` drops immediately and asynchronously, and the FIFO is flushed.
  - The async sender must be reset in the same event. No recovery of a partial handshake is provided.

## Timing
- Take edge E0 as the first `clk` edge that samples `r_i`=1.
  - `r_s`=1 after edge E(SYNC_STAGES−1).
  - The write and `a_i`↑ occur at edge E(SYNC_STAGES). With the default, that is 3 edges counting E0.
- `valid_o` and `count_o` update at the same edge as the write. Data is visible the same cycle `a_i` rises.
- `a_i`↓ follows `r_i`↓ with the same SYNC_STAGES+1-edge latency.
- Minimum handshake period is 2·(SYNC_STAGES+1) cycles plus the sender's async delays.
- `a_i` is glitch-free: one flop, no combinational path to it.

## Structure
- Package `hs_sync_pkg` holds:
  - the FSM enum `rx_state_t` {IDLE, ACK};
  - the function `ptr_w(DEPTH)` = clog2(DEPTH)+1.
- Sub-module `bitsync #(.STAGES)`: a reset-to-0 flop chain for `r_i`, reusable by a future transmit-side block.
- The FIFO memory is inline, as a register array without reset.

## Test plan
- Single word, N=8, `ready_i`=1:
  - stimulus: `d_i`=8'hA5, then `r_i`↑;
  - response: `a_i`↑ 3 edges later, `valid_o`=1 with `data_o`=8'hA5 that cycle, popped next edge;
  - after `r_i`↓: `a_i`↓ 3 edges later.
- Fill, DEPTH=4, `ready_i`=0:
  - stimulus: 5 handshakes with data 1..5;
  - response: 4 acks, `count_o`=4, and `a_i` stays 0 for the 5th request;
  - then `ready_i`=1 for one cycle: data 1 is popped, the 5th request is accepted, and the stream reads out 2,3,4,5 in order.
- Pointer wrap: 10 consecutive words 0..9 with `ready_i`=1. Output order is 0..9 and `count_o` never exceeds 1.
- Simultaneous push/pop: with `count_o`=2, complete a push on the same edge as a pop. `count_o` stays 2 and the order is preserved.
- Reset mid-operation: assert `rst`=0 while in ACK with `count_o`=3. `a_i`, `valid_o` and `count_o` go to 0 immediately, before any `clk` edge.
- `r_i` high at reset release: the request is accepted and `a_i`↑ SYNC_STAGES+1 edges after release.
